array_counter_v4: RTL
=====================

# array_counter_v4

Bank of N independent W-bit event counters with weighted increment/decrement, per-counter clear, saturating or wrapping arithmetic, registered threshold flags and a registered random-access read port. It is the next generation of the single-step array counter. It sits beside statistics/credit logic that needs per-ID tallies updated by two event streams at once, with one-cycle update latency and no stalls.

## Interface
- W, 12: counter width, ≥2
- N, 8: number of counters, ≥2, need not be a power of two
- SW, 4: step width, 1..W-1
- SAT, 1: 1 = saturate at 0 / 2^W-1, 0 = wrap modulo 2^W
- IDW, $clog2(N): ID width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inc  in  1  increment request
- inc_id  in  IDW  counter to increment
- inc_step  in  SW  increment amount (0 = no-op)
- dec  in  1  decrement request
- dec_id  in  IDW  counter to decrement
- dec_step  in  SW  decrement amount (0 = no-op)
- clr  in  1  clear request
- clr_id  in  IDW  counter to clear
- thr  in  W  common threshold, unsigned
- rd_en  in  1  read request
- rd_id  in  IDW  counter to read
- rd_vld  out  1  read data valid
- rd_data  out  W  read value
- cnt  out  W×N  unpacked array, live counter values
- at_thr  out  N  cnt[i] ≥ thr, registered
- ovf  out  N  sticky overflow flags
- unf  out  N  sticky underflow flags
- flg_clr  in  1  clears all ovf/unf

## Operation
- Every clk edge with rst=0, each counter i computes signed sum = cnt[i] + (inc && inc_id==i ? inc_step : 0) − (dec && dec_id==i ? dec_step : 0), evaluated at W+2 bits. No intermediate truncation.
- inc and dec on the same ID in the same cycle are netted, never dropped.
- sum > 2^W−1: SAT=1 → 2^W−1; SAT=0 → sum − 2^W. ovf[i] is set in both modes.
- sum < 0: SAT=1 → 0; SAT=0 → sum + 2^W. unf[i] is set in both modes.
- clr && clr_id==i forces next cnt[i]=0. Clear has priority over inc/dec to that ID, and a cleared counter raises no ovf/unf that cycle.
- IDs ≥ N on any port are ignored: no update. A read with rd_id ≥ N returns rd_data=0 with rd_vld=1.
- at_thr[i] is registered from next cnt[i] ≥ thr, using the current thr.
- ovf/unf: sticky until flg_clr. If flg_clr and a new event coincide, the set wins.
- Read port: rd_vld ← rd_en. rd_data ← cnt[rd_id] as held before the same edge's update, i.e. the value visible on cnt during the request cycle.
- There is no state machine. All storage is flops. There is no backpressure: requests are accepted every cycle.

## Timing
- Reset values: cnt[*]=0, at_thr=0, ovf=0, unf=0, rd_vld=0, rd_data=0. rst overrides every request in the same cycle.
- Update latency is 1 cycle: a request in cycle t is visible on cnt and at_thr in cycle t+1.
- Read latency is 1 cycle: rd_vld/rd_data are valid in t+1 and reflect the pre-update value.
- Back-to-back requests to the same ID every cycle accumulate exactly. No forwarding hazard exists because update is single-cycle.
- A thr change takes effect on at_thr at the next edge.
- rst asserted mid-stream discards that cycle's requests. Counting resumes the first cycle after rst deasserts.

## Configuration
- ARRAY_COUNTER_V4_FLAGS_EN defined: ovf/unf flag logic and flg_clr are implemented as above.
- Not defined: ovf and unf are constant 0 and flg_clr is ignored. Saturation/wrap arithmetic is unchanged. The ports remain present.

## Test plan
- Reset with random requests driven: all cnt=0, at_thr=0, ovf=unf=0, rd_vld=0 during reset and on the first cycle after.
- inc id3 step 5 for 3 cycles → cnt[3]=5,10,15. Then rd_en id3 → next cycle rd_vld=1, rd_data=15.
- cnt[2]=10, same cycle inc id2 step 7 + dec id2 step 3 → cnt[2]=14. Repeat with clr id2 also asserted → cnt[2]=0, ovf[2]=unf[2]=0.
- SAT=1: cnt[0]=4090, inc step 10 → 4095, ovf[0]=1. cnt[1]=0, dec step 1 → 0, unf[1]=1. SAT=0: same stimulus → cnt[0]=4, cnt[1]=4095.
- thr=8, cnt[5]=7, inc id5 step 1 → cnt[5]=8 and at_thr[5]=1 in the same cycle. Then thr=9 → at_thr[5]=0 the next cycle.
- With flags enabled: ovf[0]=1, flg_clr together with a new overflow on id0 → ovf[0] stays 1; flg_clr alone → 0. Without the macro: ovf/unf stay 0 throughout.

Source files
------------

// File: rtl/array_counter_v4_if.sv
// array_counter_v4_if: request/response bundle for the weighted counter bank.
// The flag outputs carry live data only when ARRAY_COUNTER_V4_FLAGS_EN is defined.
interface array_counter_v4_if #(
    parameter int unsigned W   = 12,
    parameter int unsigned N   = 8,
    parameter int unsigned SW  = 4,
    parameter int unsigned IDW = $clog2(N)
);
    logic           inc_i;
    logic [IDW-1:0] inc_id_i;
    logic [SW-1:0]  inc_step_i;
    logic           dec_i;
    logic [IDW-1:0] dec_id_i;
    logic [SW-1:0]  dec_step_i;
    logic           clr_i;
    logic [IDW-1:0] clr_id_i;
    logic [W-1:0]   thr_i;
    logic           rd_en_i;
    logic [IDW-1:0] rd_id_i;
    logic           flg_clr_i;
    logic           rd_vld_o;
    logic [W-1:0]   rd_data_o;
    logic [W-1:0]   cnt_o [N];
    logic [N-1:0]   at_thr_o;
    logic [N-1:0]   ovf_o;
    logic [N-1:0]   unf_o;

    modport slave (
        input  inc_i, inc_id_i, inc_step_i,
        input  dec_i, dec_id_i, dec_step_i,
        input  clr_i, clr_id_i, thr_i,
        input  rd_en_i, rd_id_i, flg_clr_i,
        output rd_vld_o, rd_data_o, cnt_o, at_thr_o, ovf_o, unf_o
    );

    modport master (
        output inc_i, inc_id_i, inc_step_i,
        output dec_i, dec_id_i, dec_step_i,
        output clr_i, clr_id_i, thr_i,
        output rd_en_i, rd_id_i, flg_clr_i,
        input  rd_vld_o, rd_data_o, cnt_o, at_thr_o, ovf_o, unf_o
    );
endinterface

// File: rtl/array_counter_v4.sv
// array_counter_v4: N independent W-bit counters with netted weighted inc/dec,
// per-counter clear, saturate (SAT=1) or wrap (SAT=0), registered threshold
// flags and a registered read port returning the pre-update value.
// Optional macro ARRAY_COUNTER_V4_FLAGS_EN enables sticky ovf/unf flags and flg_clr.
module array_counter_v4 #(
    parameter int unsigned W   = 12,
    parameter int unsigned N   = 8,
    parameter int unsigned SW  = 4,
    parameter int unsigned SAT = 1,
    parameter int unsigned IDW = $clog2(N)
) (
    input logic              clk,
    input logic              rst,
    array_counter_v4_if.slave bus
);
    // Two guard bits: bit W flags overflow, bit W+1 (sign) flags underflow.
    localparam int unsigned SUMW = W + 2;

    logic [SUMW-1:0] sum [N];
    logic [W-1:0]    cnt_q [N];
    logic [W-1:0]    cnt_d [N];
    logic [N-1:0]    at_thr_q, at_thr_d;
    logic [N-1:0]    ovf_q, ovf_d, unf_q, unf_d;
    logic [N-1:0]    ovf_evt, unf_evt;
    logic            rd_vld_q, rd_vld_d;
    logic [W-1:0]    rd_data_q, rd_data_d;

    // Per-counter netted update, clear priority, saturate/wrap and threshold compare
    always_comb begin
        ovf_evt  = '0;
        unf_evt  = '0;
        at_thr_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = SUMW'(cnt_q[i]);
            if (bus.inc_i && (bus.inc_id_i == IDW'(i))) begin
                sum[i] = sum[i] + SUMW'(bus.inc_step_i);
            end
            if (bus.dec_i && (bus.dec_id_i == IDW'(i))) begin
                sum[i] = sum[i] - SUMW'(bus.dec_step_i);
            end
            cnt_d[i] = sum[i][W-1:0];
            if (bus.clr_i && (bus.clr_id_i == IDW'(i))) begin
                cnt_d[i] = '0;
            end else if (sum[i][W+1]) begin
                unf_evt[i] = 1'b1;
                if (SAT != 0) begin
                    cnt_d[i] = '0;
                end
            end else if (sum[i][W]) begin
                ovf_evt[i] = 1'b1;
                if (SAT != 0) begin
                    cnt_d[i] = '1;
                end
            end
            at_thr_d[i] = (cnt_d[i] >= bus.thr_i);
        end
    end

    // Read port samples the counter value held before this edge's update
    always_comb begin
        rd_vld_d  = bus.rd_en_i;
        rd_data_d = rd_data_q;
        if (bus.rd_en_i) begin
            rd_data_d = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.rd_id_i == IDW'(i)) begin
                    rd_data_d = cnt_q[i];
                end
            end
        end
    end

`ifdef ARRAY_COUNTER_V4_FLAGS_EN
    // Sticky flags: a new event wins over a coincident flg_clr
    always_comb begin
        ovf_d = (ovf_q & ~{N{bus.flg_clr_i}}) | ovf_evt;
        unf_d = (unf_q & ~{N{bus.flg_clr_i}}) | unf_evt;
    end
`else
    // Flags disabled: held at zero, flg_clr has no effect
    always_comb begin
        ovf_d = '0;
        unf_d = '0;
    end

    logic unused_flags;
    assign unused_flags = ^{bus.flg_clr_i, ovf_evt, unf_evt};
`endif

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '{default: '0};
            at_thr_q  <= '0;
            ovf_q     <= '0;
            unf_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            at_thr_q  <= at_thr_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.cnt_o     = cnt_q;
    assign bus.at_thr_o  = at_thr_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.unf_o     = unf_q;
    assign bus.rd_vld_o  = rd_vld_q;
    assign bus.rd_data_o = rd_data_q;

endmodule
